// File: rtl/onchip_mem_pkg.sv
// Shared types and constants for the two-requester on-chip memory arbiter.
// Holds the port index type, the read return latency and the default memory depth.
package onchip_mem_pkg;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_idx_t;

   localparam int RD_LATENCY    = 2;
   localparam int DEFAULT_DEPTH = 40000;

   function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] depth);
      return (addr < depth);
   endfunction

   function automatic port_idx_t other_port(input port_idx_t p);
      return (p == PORT0) ? PORT1 : PORT0;
   endfunction

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Requester-side bus of the on-chip memory arbiter (Avalon-style word port).
// The requester drives commands through the master modport; the arbiter uses slave.
interface onchip_mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic [DATA_W/8-1:0] byteenable;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/onchip_mem_arbiter_rr.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to port rr.
// Purely combinational; the rr pointer lives in the parent.
module rr_arbiter2
   import onchip_mem_pkg::*;
(
   input  logic [1:0] req,
   input  port_idx_t  rr,
   output port_idx_t  grant,
   output logic       accept
);

   // Grant decode from the current request pair.
   always_comb begin
      grant  = PORT0;
      accept = 1'b0;
      case (req)
         2'b01: begin
            grant  = PORT0;
            accept = 1'b1;
         end
         2'b10: begin
            grant  = PORT1;
            accept = 1'b1;
         end
         2'b11: begin
            grant  = rr;
            accept = 1'b1;
         end
         default: begin
            grant  = PORT0;
            accept = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Arbitrates two requesters onto one synchronous on-chip RAM with a fixed two-cycle
// read return, out-of-range protection and a global freeze.
module onchip_mem_arbiter
   import onchip_mem_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int DEPTH  = DEFAULT_DEPTH
) (
   input  logic                clk,
   input  logic                reset_n,
   onchip_mem_arbiter_if.slave m0,
   onchip_mem_arbiter_if.slave m1,
   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata,
   input  logic                freeze,
   output logic                range_err
);

   logic                run_s;
   logic [1:0]          req_s;
   port_idx_t           grant_s;
   logic                accept_s;
   logic [ADDR_W-1:0]   sel_address_s;
   logic [DATA_W/8-1:0] sel_byteenable_s;
   logic [DATA_W-1:0]   sel_writedata_s;
   logic                sel_write_s;
   logic                in_range_s;

   port_idx_t           rr_r;
   logic [ADDR_W-1:0]   last_address_r;
   logic [DATA_W/8-1:0] last_byteenable_r;
   logic [DATA_W-1:0]   last_writedata_r;
   logic                range_err_r;
   logic                pipe_valid_r;
   port_idx_t           pipe_port_r;
   logic                pipe_oor_r;
   logic                rdv0_r;
   logic                rdv1_r;
   logic [DATA_W-1:0]   rd0_r;
   logic [DATA_W-1:0]   rd1_r;

   // Requests are masked while in reset or frozen so nothing can be accepted then.
   assign run_s = reset_n & ~freeze;
   assign req_s = {run_s & (m1.read | m1.write), run_s & (m0.read | m0.write)};

   rr_arbiter2 u_arb (
      .req    (req_s),
      .rr     (rr_r),
      .grant  (grant_s),
      .accept (accept_s)
   );

   // Select the granted command; read+write together is handled as a write.
   always_comb begin
      sel_address_s    = m0.address;
      sel_byteenable_s = m0.byteenable;
      sel_writedata_s  = m0.writedata;
      sel_write_s      = m0.write;
      case (grant_s)
         PORT1: begin
            sel_address_s    = m1.address;
            sel_byteenable_s = m1.byteenable;
            sel_writedata_s  = m1.writedata;
            sel_write_s      = m1.write;
         end
         default: begin
            sel_address_s    = m0.address;
            sel_byteenable_s = m0.byteenable;
            sel_writedata_s  = m0.writedata;
            sel_write_s      = m0.write;
         end
      endcase
      in_range_s = addr_in_range(64'(sel_address_s), 64'(DEPTH));
   end

   // Memory-side drive; an idle bus keeps presenting the last accepted command.
   always_comb begin
      mem_chipselect = accept_s & in_range_s;
      mem_write      = accept_s & in_range_s & sel_write_s;
      mem_clken      = ~reset_n | ~freeze;
      if (accept_s) begin
         mem_address    = sel_address_s;
         mem_byteenable = sel_byteenable_s;
         mem_writedata  = sel_writedata_s;
      end else begin
         mem_address    = last_address_r;
         mem_byteenable = last_byteenable_r;
         mem_writedata  = last_writedata_r;
      end
   end

   assign m0.waitrequest   = ~run_s | ((m0.read | m0.write) & ~(accept_s & (grant_s == PORT0)));
   assign m1.waitrequest   = ~run_s | ((m1.read | m1.write) & ~(accept_s & (grant_s == PORT1)));
   assign m0.readdata      = rd0_r;
   assign m1.readdata      = rd1_r;
   assign m0.readdatavalid = rdv0_r;
   assign m1.readdatavalid = rdv1_r;
   assign range_err        = range_err_r;

   // Round-robin pointer, idle-hold copy of the bus and the sticky range flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_r              <= PORT0;
         last_address_r    <= {ADDR_W{1'b0}};
         last_byteenable_r <= {(DATA_W/8){1'b0}};
         last_writedata_r  <= {DATA_W{1'b0}};
         range_err_r       <= 1'b0;
      end else if (accept_s) begin
         rr_r              <= other_port(grant_s);
         last_address_r    <= sel_address_s;
         last_byteenable_r <= sel_byteenable_s;
         last_writedata_r  <= sel_writedata_s;
         if (!in_range_s) begin
            range_err_r <= 1'b1;
         end
      end
   end

   // Read return: tag stage at accept, data stage one cycle later; freeze holds the
   // tag stage and drops any valid so each read still pulses exactly once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_valid_r <= 1'b0;
         pipe_port_r  <= PORT0;
         pipe_oor_r   <= 1'b0;
         rdv0_r       <= 1'b0;
         rdv1_r       <= 1'b0;
         rd0_r        <= {DATA_W{1'b0}};
         rd1_r        <= {DATA_W{1'b0}};
      end else if (freeze) begin
         rdv0_r <= 1'b0;
         rdv1_r <= 1'b0;
      end else begin
         pipe_valid_r <= accept_s & ~sel_write_s;
         pipe_port_r  <= grant_s;
         pipe_oor_r   <= ~in_range_s;
         rdv0_r       <= pipe_valid_r & (pipe_port_r == PORT0);
         rdv1_r       <= pipe_valid_r & (pipe_port_r == PORT1);
         if (pipe_valid_r && (pipe_port_r == PORT0)) begin
            rd0_r <= pipe_oor_r ? {DATA_W{1'b0}} : mem_readdata;
         end
         if (pipe_valid_r && (pipe_port_r == PORT1)) begin
            rd1_r <= pipe_oor_r ? {DATA_W{1'b0}} : mem_readdata;
         end
      end
   end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Randomised and directed bench for onchip_mem_arbiter against a queue-based reference
// model of grants, memory contents and read returns.
module tb_onchip_mem_arbiter;
   localparam int DEPTH = 40000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        freeze;
   logic [15:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic        mem_chipselect;
   logic        mem_write;
   logic [31:0] mem_writedata;
   logic        mem_clken;
   logic [31:0] mem_readdata;
   logic        range_err;

   onchip_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) m0_if ();
   onchip_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) m1_if ();

   onchip_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .m0             (m0_if),
      .m1             (m1_if),
      .mem_address    (mem_address),
      .mem_byteenable (mem_byteenable),
      .mem_chipselect (mem_chipselect),
      .mem_write      (mem_write),
      .mem_writedata  (mem_writedata),
      .mem_clken      (mem_clken),
      .mem_readdata   (mem_readdata),
      .freeze         (freeze),
      .range_err      (range_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int i);
      if (i == 16) return 32'hA5A5_0001;
      if (i == 32) return 32'hFFFF_FFFF;
      return (32'(i) * 32'h0001_0003) ^ 32'hC3C3_0000;
   endfunction

   // Synchronous RAM on the memory side
   logic [31:0] ram [0:DEPTH-1];
   initial begin
      for (int i = 0; i < DEPTH; i++) ram[i] = init_word(i);
      mem_readdata = 32'h0;
      forever begin
         @(posedge clk);
         if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
               for (int b = 0; b < 4; b++)
                  if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
               mem_readdata <= ram[mem_address];
            end
         end
      end
   end

   // Reference model state
   typedef struct {
      int          port;
      logic [31:0] data;
      int          stage;
   } rd_item_t;

   rd_item_t    pend[$];
   logic [31:0] shadow [0:DEPTH-1];
   logic [31:0] last_rd [2];
   logic [15:0] last_addr_m;
   int          rr_m;
   bit          rerr_m;

   // Stimulus state
   bit          rstn_v, frz;
   bit          rd [2];
   bit          wr [2];
   logic [15:0] ad [2];
   logic [3:0]  be [2];
   logic [31:0] wd [2];
   bit          acc [2];

   int n_total, n_bad;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic set_cmd(input int p, input bit r, input bit w, input logic [15:0] a,
                          input logic [3:0] b, input logic [31:0] d);
      rd[p] = r; wr[p] = w; ad[p] = a; be[p] = b; wd[p] = d;
   endtask

   task automatic idle_all();
      for (int p = 0; p < 2; p++) set_cmd(p, 1'b0, 1'b0, 16'h0, 4'h0, 32'h0);
   endtask

   // One clock cycle: drive, check mid-cycle, advance the model across the edge
   task automatic tick();
      bit          req [2];
      bit          run, inr, exp_v [2];
      int          g;
      logic        wq [2];
      logic        rv [2];
      logic [31:0] rdt [2];

      reset_n = rstn_v; freeze = frz;
      m0_if.read = rd[0]; m0_if.write = wr[0]; m0_if.address = ad[0];
      m0_if.byteenable = be[0]; m0_if.writedata = wd[0];
      m1_if.read = rd[1]; m1_if.write = wr[1]; m1_if.address = ad[1];
      m1_if.byteenable = be[1]; m1_if.writedata = wd[1];
      acc[0] = 1'b0; acc[1] = 1'b0;
      #4;
      if (!rstn_v) begin
         pend.delete();
         rr_m = 0; rerr_m = 1'b0; last_addr_m = 16'h0;
         last_rd[0] = 32'h0; last_rd[1] = 32'h0;
      end
      for (int p = 0; p < 2; p++) req[p] = rd[p] | wr[p];
      run = rstn_v && !frz;
      g = -1;
      if (run) begin
         if (req[0] && req[1]) g = rr_m;
         else if (req[0]) g = 0;
         else if (req[1]) g = 1;
      end
      inr = (g >= 0) && (int'(ad[g]) < DEPTH);

      wq[0] = m0_if.waitrequest; wq[1] = m1_if.waitrequest;
      rv[0] = m0_if.readdatavalid; rv[1] = m1_if.readdatavalid;
      rdt[0] = m0_if.readdata; rdt[1] = m1_if.readdata;

      exp_v[0] = 1'b0; exp_v[1] = 1'b0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
         if (pend[i].stage == 2) begin
            exp_v[pend[i].port] = 1'b1;
            last_rd[pend[i].port] = pend[i].data;
            pend.delete(i);
         end
      end

      for (int p = 0; p < 2; p++) begin
         check_eq($sformatf("waitrequest%0d", p), 64'(wq[p]),
                  64'(!run || (req[p] && (g != p))));
         check_eq($sformatf("readdatavalid%0d", p), 64'(rv[p]), 64'(exp_v[p]));
         check_eq($sformatf("readdata%0d", p), 64'(rdt[p]), 64'(last_rd[p]));
      end
      check_eq("mem_clken", 64'(mem_clken), 64'(!rstn_v || !frz));
      check_eq("mem_chipselect", 64'(mem_chipselect), 64'(inr));
      check_eq("mem_write", 64'(mem_write), 64'(inr && wr[g]));
      check_eq("mem_address", 64'(mem_address), 64'((g >= 0) ? ad[g] : last_addr_m));
      check_eq("range_err", 64'(range_err), 64'(rerr_m));

      if (rstn_v) begin
         if (!frz) foreach (pend[i]) pend[i].stage++;
         if (g >= 0) begin
            acc[g] = 1'b1;
            rr_m = 1 - g;
            last_addr_m = ad[g];
            if (!inr) rerr_m = 1'b1;
            if (wr[g]) begin
               if (inr)
                  for (int b = 0; b < 4; b++)
                     if (be[g][b]) shadow[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
            end else begin
               pend.push_back('{port: g, data: (inr ? shadow[ad[g]] : 32'h0), stage: 1});
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      n_total = 0; n_bad = 0;
      for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
      rr_m = 0; rerr_m = 1'b0; last_addr_m = 16'h0;
      last_rd[0] = 32'h0; last_rd[1] = 32'h0;
      rstn_v = 1'b0; frz = 1'b0;
      idle_all();
      reset_n = 1'b0; freeze = 1'b0;
      @(posedge clk);
      #1;
      tick();
      set_cmd(0, 1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
      tick();                                   // requesting during reset: held off
      rstn_v = 1'b1;
      tick();                                   // accepted at first edge after release
      idle_all();
      repeat (3) tick();

      // Both ports write back to back: grants alternate
      for (int i = 0; i < 8; i++) begin
         for (int p = 0; p < 2; p++)
            if (acc[p] || !(rd[p] || wr[p]))
               set_cmd(p, 1'b0, 1'b1, 16'(40 + 2*i + p), 4'hF, $urandom);
         tick();
      end
      idle_all();
      tick();

      // Partial byte write then read back
      set_cmd(1, 1'b0, 1'b1, 16'h0020, 4'b0011, 32'h1234_5678);
      tick();
      set_cmd(1, 1'b1, 1'b0, 16'h0020, 4'hF, 32'h0);
      tick();
      idle_all();
      repeat (3) tick();

      // Out-of-range read
      set_cmd(0, 1'b1, 1'b0, 16'(40000), 4'hF, 32'h0);
      tick();
      idle_all();
      repeat (4) tick();

      // Interleaved reads on consecutive cycles
      set_cmd(0, 1'b1, 1'b0, 16'h0001, 4'hF, 32'h0); tick(); idle_all();
      set_cmd(1, 1'b1, 1'b0, 16'h0002, 4'hF, 32'h0); tick(); idle_all();
      set_cmd(0, 1'b1, 1'b0, 16'h0003, 4'hF, 32'h0); tick(); idle_all();
      repeat (4) tick();

      // Freeze with a read in flight and a write held off
      set_cmd(0, 1'b1, 1'b0, 16'h0010, 4'hF, 32'h0);
      tick();
      idle_all();
      set_cmd(1, 1'b0, 1'b1, 16'h0011, 4'hF, 32'hCAFE_F00D);
      frz = 1'b1;
      repeat (3) tick();
      frz = 1'b0;
      tick();
      idle_all();
      repeat (3) tick();

      // Reset with a read in flight: no return, pointer back to port 0
      set_cmd(0, 1'b1, 1'b0, 16'h0005, 4'hF, 32'h0);
      tick();
      idle_all();
      rstn_v = 1'b0;
      tick();
      rstn_v = 1'b1;
      set_cmd(0, 1'b0, 1'b1, 16'h0006, 4'hF, 32'h1111_2222);
      set_cmd(1, 1'b0, 1'b1, 16'h0007, 4'hF, 32'h3333_4444);
      tick();
      idle_all();
      repeat (4) tick();

      // Random traffic with held commands, occasional freeze and bad addresses
      for (int c = 0; c < 500; c++) begin
         frz = ($urandom_range(0, 11) == 0);
         for (int p = 0; p < 2; p++) begin
            if (acc[p] || !(rd[p] || wr[p])) begin
               k = $urandom_range(0, 9);
               rd[p] = (k < 4) || (k == 8);
               wr[p] = ((k >= 4) && (k < 8)) || (k == 8);
               ad[p] = ($urandom_range(0, 19) == 0) ? 16'(39998 + $urandom_range(0, 3))
                                                    : 16'($urandom_range(0, 31));
               be[p] = 4'($urandom);
               wd[p] = $urandom;
            end
         end
         tick();
      end
      frz = 1'b0;
      idle_all();
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
